// File: rtl/mips_pkg.sv
// Shared opcode constants and control-bundle types for the MIPS ID stage.
// Extended opcodes are only decoded when ID_EXT_OPS_EN is defined.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [1:0] {
    DST_NONE,
    DST_RD,
    DST_RT,
    DST_R31
  } dst_sel_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     jump;
    logic     alu_src;
    logic     zext;
    dst_sel_e dst_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] imm;
    logic [25:0] jaddr;
    logic [5:0]  funct;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
  } idex_t;

endpackage

// File: rtl/mips_instruction_decode_if.sv
// Signal bundle between IF/ID, the ID stage and the execute stage.
// Extra class flags exist only when ID_EXT_OPS_EN is defined.
interface mips_instruction_decode_if;
  logic [31:0] instruction;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] immediate;
  logic [31:0] imm_sext;
  logic [25:0] jump_address;
  logic        is_rtype, is_lw, is_sw, is_beq, is_jump, illegal;
`ifdef ID_EXT_OPS_EN
  logic        is_itype_alu, is_jal;
`endif
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic [31:0] id_imm;
  logic [25:0] id_jaddr;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_src;
  logic [5:0]  id_funct;

  modport slave (
    input  instruction, in_valid, stall, flush,
    output opcode, rs, rt, rd, shamt, funct, immediate, imm_sext, jump_address,
           is_rtype, is_lw, is_sw, is_beq, is_jump, illegal,
`ifdef ID_EXT_OPS_EN
           is_itype_alu, is_jal,
`endif
           id_valid, id_rs, id_rt, id_dst, id_imm, id_jaddr,
           id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_src, id_funct
  );

  modport master (
    output instruction, in_valid, stall, flush,
    input  opcode, rs, rt, rd, shamt, funct, immediate, imm_sext, jump_address,
           is_rtype, is_lw, is_sw, is_beq, is_jump, illegal,
`ifdef ID_EXT_OPS_EN
           is_itype_alu, is_jal,
`endif
           id_valid, id_rs, id_rt, id_dst, id_imm, id_jaddr,
           id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_src, id_funct
  );
endinterface

// File: rtl/id_ctrl_decode.sv
// Combinational opcode -> class flags and control bundle.
// ID_EXT_OPS_EN adds addi/andi/ori/slti/jal decoding.
module id_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       is_rtype_o,
  output logic       is_lw_o,
  output logic       is_sw_o,
  output logic       is_beq_o,
  output logic       is_jump_o,
`ifdef ID_EXT_OPS_EN
  output logic       is_itype_alu_o,
  output logic       is_jal_o,
`endif
  output logic       illegal_o
);

  logic ext_hit;

  always_comb begin
    ctrl_o     = CTRL_BUBBLE;
    is_rtype_o = 1'b0;
    is_lw_o    = 1'b0;
    is_sw_o    = 1'b0;
    is_beq_o   = 1'b0;
    is_jump_o  = 1'b0;
    ext_hit    = 1'b0;
`ifdef ID_EXT_OPS_EN
    is_itype_alu_o = 1'b0;
    is_jal_o       = 1'b0;
`endif
    case (opcode_i)
      OP_RTYPE: begin
        is_rtype_o       = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.dst_sel   = DST_RD;
      end
      OP_LW: begin
        is_lw_o          = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.dst_sel   = DST_RT;
      end
      OP_SW: begin
        is_sw_o          = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        is_beq_o      = 1'b1;
        ctrl_o.branch = 1'b1;
      end
      OP_J: begin
        is_jump_o   = 1'b1;
        ctrl_o.jump = 1'b1;
      end
`ifdef ID_EXT_OPS_EN
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        is_itype_alu_o   = 1'b1;
        ext_hit          = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.dst_sel   = DST_RT;
        ctrl_o.zext      = (opcode_i == OP_ANDI) || (opcode_i == OP_ORI);
      end
      OP_JAL: begin
        is_jal_o         = 1'b1;
        ext_hit          = 1'b1;
        ctrl_o.jump      = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.dst_sel   = DST_R31;
      end
`endif
      default: ;
    endcase
    illegal_o = ~(is_rtype_o | is_lw_o | is_sw_o | is_beq_o | is_jump_o | ext_hit);
  end

endmodule

// File: rtl/mips_instruction_decode.sv
// MIPS ID stage: field slicing, class decode and the ID/EX pipeline register.
// ID_EXT_OPS_EN enables the extended I-type ALU and jal opcodes.
module mips_instruction_decode
  import mips_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  mips_instruction_decode_if.slave  bus
);

  ctrl_t       ctrl, ctrl_eff;
  logic        illegal, load_valid;
  logic [31:0] imm_ext;
  logic [4:0]  dst;
  idex_t       idex_d, idex_q;

  assign bus.opcode       = bus.instruction[31:26];
  assign bus.rs           = bus.instruction[25:21];
  assign bus.rt           = bus.instruction[20:16];
  assign bus.rd           = bus.instruction[15:11];
  assign bus.shamt        = bus.instruction[10:6];
  assign bus.funct        = bus.instruction[5:0];
  assign bus.immediate    = bus.instruction[15:0];
  assign bus.imm_sext     = {{16{bus.instruction[15]}}, bus.instruction[15:0]};
  assign bus.jump_address = bus.instruction[25:0];
  assign bus.illegal      = illegal;

  id_ctrl_decode u_ctrl (
    .opcode_i       (bus.opcode),
    .ctrl_o         (ctrl),
    .is_rtype_o     (bus.is_rtype),
    .is_lw_o        (bus.is_lw),
    .is_sw_o        (bus.is_sw),
    .is_beq_o       (bus.is_beq),
    .is_jump_o      (bus.is_jump),
`ifdef ID_EXT_OPS_EN
    .is_itype_alu_o (bus.is_itype_alu),
    .is_jal_o       (bus.is_jal),
`endif
    .illegal_o      (illegal)
  );

  // Invalid or illegal words enter ID/EX as bubbles, so gate controls here.
  always_comb begin
    load_valid = bus.in_valid & ~illegal;
    ctrl_eff   = load_valid ? ctrl : CTRL_BUBBLE;
    imm_ext    = ctrl_eff.zext ? {16'h0000, bus.immediate} : bus.imm_sext;
    case (ctrl_eff.dst_sel)
      DST_RD:  dst = bus.rd;
      DST_RT:  dst = bus.rt;
      DST_R31: dst = 5'd31;
      default: dst = '0;
    endcase
  end

  always_comb begin
    idex_d = idex_q;
    if (bus.flush) begin
      idex_d = '0;
    end else if (!bus.stall) begin
      idex_d.valid     = load_valid;
      idex_d.rs        = bus.rs;
      idex_d.rt        = bus.rt;
      idex_d.dst       = dst;
      idex_d.imm       = imm_ext;
      idex_d.jaddr     = bus.jump_address;
      idex_d.funct     = bus.funct;
      idex_d.reg_write = ctrl_eff.reg_write;
      idex_d.mem_read  = ctrl_eff.mem_read;
      idex_d.mem_write = ctrl_eff.mem_write;
      idex_d.branch    = ctrl_eff.branch;
      idex_d.jump      = ctrl_eff.jump;
      idex_d.alu_src   = ctrl_eff.alu_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign bus.id_valid     = idex_q.valid;
  assign bus.id_rs        = idex_q.rs;
  assign bus.id_rt        = idex_q.rt;
  assign bus.id_dst       = idex_q.dst;
  assign bus.id_imm       = idex_q.imm;
  assign bus.id_jaddr     = idex_q.jaddr;
  assign bus.id_funct     = idex_q.funct;
  assign bus.id_reg_write = idex_q.reg_write;
  assign bus.id_mem_read  = idex_q.mem_read;
  assign bus.id_mem_write = idex_q.mem_write;
  assign bus.id_branch    = idex_q.branch;
  assign bus.id_jump      = idex_q.jump;
  assign bus.id_alu_src   = idex_q.alu_src;

endmodule

// File: tb/tb_mips_instruction_decode.sv
// Directed self-checking bench for mips_instruction_decode.
// Covers the ID_EXT_OPS_EN opcodes in whichever build is selected.
module tb_mips_instruction_decode;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned tests = 0;
  int unsigned fails = 0;

  mips_instruction_decode_if bus ();

  mips_instruction_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] all_id();
    return {bus.id_valid, bus.id_rs, bus.id_rt, bus.id_dst, bus.id_imm, bus.id_jaddr,
            bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_branch,
            bus.id_jump, bus.id_alu_src, bus.id_funct};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic v, input logic st, input logic fl);
    @(negedge clk);
    bus.instruction = instr;
    bus.in_valid    = v;
    bus.stall       = st;
    bus.flush       = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.instruction = 32'h012A4020;
    bus.in_valid = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (all_id() !== '0) begin
      fails++; $display("FAIL reset_state: got %h expected 0", all_id());
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    drive(32'h012A4020, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({bus.opcode, bus.rs, bus.rt, bus.rd, bus.funct, bus.is_rtype, bus.illegal} !==
        {6'd0, 5'd9, 5'd10, 5'd8, 6'h20, 1'b1, 1'b0}) begin
      fails++; $display("FAIL rtype_fields: got op=%h rs=%0d rt=%0d rd=%0d fn=%h rt_flag=%b ill=%b expected 0/9/10/8/20/1/0",
                        bus.opcode, bus.rs, bus.rt, bus.rd, bus.funct, bus.is_rtype, bus.illegal);
    end
    tick();
    tests++;
    if ({bus.id_valid, bus.id_dst, bus.id_reg_write, bus.id_mem_read, bus.id_alu_src, bus.id_funct} !==
        {1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 6'h20}) begin
      fails++; $display("FAIL rtype_reg: got v=%b dst=%0d rw=%b mr=%b as=%b fn=%h expected 1/8/1/0/0/20",
                        bus.id_valid, bus.id_dst, bus.id_reg_write, bus.id_mem_read, bus.id_alu_src, bus.id_funct);
    end
  endtask

  task automatic test_lw();
    drive(32'h8D280004, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({bus.rs, bus.rt, bus.immediate, bus.is_lw, bus.is_rtype} !== {5'd9, 5'd8, 16'h0004, 1'b1, 1'b0}) begin
      fails++; $display("FAIL lw_fields: got rs=%0d rt=%0d imm=%h is_lw=%b is_r=%b expected 9/8/0004/1/0",
                        bus.rs, bus.rt, bus.immediate, bus.is_lw, bus.is_rtype);
    end
    tick();
    tests++;
    if ({bus.id_mem_read, bus.id_reg_write, bus.id_alu_src, bus.id_dst, bus.id_imm, bus.id_rs} !==
        {1'b1, 1'b1, 1'b1, 5'd8, 32'h4, 5'd9}) begin
      fails++; $display("FAIL lw_reg: got mr=%b rw=%b as=%b dst=%0d imm=%h rs=%0d expected 1/1/1/8/00000004/9",
                        bus.id_mem_read, bus.id_reg_write, bus.id_alu_src, bus.id_dst, bus.id_imm, bus.id_rs);
    end
  endtask

  task automatic test_sw();
    drive(32'hAD280004, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({bus.is_sw, bus.is_lw} !== 2'b10) begin
      fails++; $display("FAIL sw_flag: got sw=%b lw=%b expected 1/0", bus.is_sw, bus.is_lw);
    end
    tick();
    tests++;
    if ({bus.id_mem_write, bus.id_reg_write, bus.id_mem_read, bus.id_dst} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      fails++; $display("FAIL sw_reg: got mw=%b rw=%b mr=%b dst=%0d expected 1/0/0/0",
                        bus.id_mem_write, bus.id_reg_write, bus.id_mem_read, bus.id_dst);
    end
  endtask

  task automatic test_jump_beq();
    drive(32'h08010000, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({bus.jump_address, bus.is_jump} !== {26'h0010000, 1'b1}) begin
      fails++; $display("FAIL j_fields: got ja=%h is_j=%b expected 0010000/1", bus.jump_address, bus.is_jump);
    end
    tick();
    tests++;
    if ({bus.id_jump, bus.id_jaddr, bus.id_reg_write, bus.id_branch} !== {1'b1, 26'h0010000, 1'b0, 1'b0}) begin
      fails++; $display("FAIL j_reg: got jmp=%b ja=%h rw=%b br=%b expected 1/0010000/0/0",
                        bus.id_jump, bus.id_jaddr, bus.id_reg_write, bus.id_branch);
    end
    drive(32'h1109FFFF, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({bus.imm_sext, bus.is_beq, bus.is_jump} !== {32'hFFFFFFFF, 1'b1, 1'b0}) begin
      fails++; $display("FAIL beq_fields: got sext=%h beq=%b j=%b expected ffffffff/1/0",
                        bus.imm_sext, bus.is_beq, bus.is_jump);
    end
    tick();
    tests++;
    if ({bus.id_branch, bus.id_imm, bus.id_dst, bus.id_jump} !== {1'b1, 32'hFFFFFFFF, 5'd0, 1'b0}) begin
      fails++; $display("FAIL beq_reg: got br=%b imm=%h dst=%0d jmp=%b expected 1/ffffffff/0/0",
                        bus.id_branch, bus.id_imm, bus.id_dst, bus.id_jump);
    end
  endtask

  task automatic test_illegal();
    drive(32'hFC000000, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({bus.illegal, bus.is_rtype, bus.is_lw, bus.is_sw, bus.is_beq, bus.is_jump} !== 6'b100000) begin
      fails++; $display("FAIL illegal_flag: got %b expected 100000",
                        {bus.illegal, bus.is_rtype, bus.is_lw, bus.is_sw, bus.is_beq, bus.is_jump});
    end
    tick();
    tests++;
    if ({bus.id_valid, bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_branch, bus.id_jump,
         bus.id_alu_src} !== 7'b0) begin
      fails++; $display("FAIL illegal_reg: got valid=%b ctrls=%b expected 0/000000", bus.id_valid,
                        {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_branch, bus.id_jump, bus.id_alu_src});
    end
    drive(32'h012A4020, 1'b0, 1'b0, 1'b0);
    tick();
    tests++;
    if ({bus.id_valid, bus.id_reg_write, bus.id_dst} !== {1'b0, 1'b0, 5'd0}) begin
      fails++; $display("FAIL invalid_in: got v=%b rw=%b dst=%0d expected 0/0/0", bus.id_valid, bus.id_reg_write, bus.id_dst);
    end
  endtask

  task automatic test_stall_flush();
    drive(32'h012A4020, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h8D280004, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    tests++;
    if ({bus.id_valid, bus.id_dst, bus.id_reg_write, bus.id_mem_read, bus.id_rt, bus.id_funct} !==
        {1'b1, 5'd8, 1'b1, 1'b0, 5'd10, 6'h20}) begin
      fails++; $display("FAIL stall_hold: got v=%b dst=%0d rw=%b mr=%b rt=%0d fn=%h expected 1/8/1/0/10/20",
                        bus.id_valid, bus.id_dst, bus.id_reg_write, bus.id_mem_read, bus.id_rt, bus.id_funct);
    end
    drive(32'h8D280004, 1'b1, 1'b1, 1'b1);
    tick();
    tests++;
    if ({bus.id_valid, bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_branch, bus.id_jump,
         bus.id_alu_src} !== 7'b0) begin
      fails++; $display("FAIL flush_over_stall: got valid=%b ctrls=%b expected 0/000000", bus.id_valid,
                        {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_branch, bus.id_jump, bus.id_alu_src});
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h8D280004, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'hAD280004, 1'b1, 1'b0, 1'b0);
    tick();
    tests++;
    if ({bus.id_mem_write, bus.id_mem_read, bus.id_valid} !== 3'b101) begin
      fails++; $display("FAIL back_to_back: got mw=%b mr=%b v=%b expected 1/0/1", bus.id_mem_write, bus.id_mem_read, bus.id_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(32'h8D280004, 1'b1, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (all_id() !== '0) begin
      fails++; $display("FAIL reset_async: got %h expected 0", all_id());
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if ({bus.id_valid, bus.id_mem_read, bus.id_dst} !== {1'b1, 1'b1, 5'd8}) begin
      fails++; $display("FAIL reset_release: got v=%b mr=%b dst=%0d expected 1/1/8", bus.id_valid, bus.id_mem_read, bus.id_dst);
    end
  endtask

  task automatic test_ext_ops();
`ifdef ID_EXT_OPS_EN
    drive(32'h2128FFFF, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({bus.is_itype_alu, bus.illegal} !== 2'b10) begin
      fails++; $display("FAIL addi_flag: got it=%b ill=%b expected 1/0", bus.is_itype_alu, bus.illegal);
    end
    tick();
    tests++;
    if ({bus.id_imm, bus.id_dst, bus.id_reg_write, bus.id_alu_src} !== {32'hFFFFFFFF, 5'd8, 1'b1, 1'b1}) begin
      fails++; $display("FAIL addi_reg: got imm=%h dst=%0d rw=%b as=%b expected ffffffff/8/1/1",
                        bus.id_imm, bus.id_dst, bus.id_reg_write, bus.id_alu_src);
    end
    drive(32'h3128FFFF, 1'b1, 1'b0, 1'b0);
    tick();
    tests++;
    if (bus.id_imm !== 32'h0000FFFF) begin
      fails++; $display("FAIL andi_zext: got %h expected 0000ffff", bus.id_imm);
    end
    drive(32'h0C000010, 1'b1, 1'b0, 1'b0);
    tests++;
    if (bus.is_jal !== 1'b1) begin
      fails++; $display("FAIL jal_flag: got %b expected 1", bus.is_jal);
    end
    tick();
    tests++;
    if ({bus.id_jump, bus.id_reg_write, bus.id_dst} !== {1'b1, 1'b1, 5'd31}) begin
      fails++; $display("FAIL jal_reg: got jmp=%b rw=%b dst=%0d expected 1/1/31", bus.id_jump, bus.id_reg_write, bus.id_dst);
    end
`else
    drive(32'h2128FFFF, 1'b1, 1'b0, 1'b0);
    tests++;
    if (bus.illegal !== 1'b1) begin
      fails++; $display("FAIL addi_illegal: got %b expected 1", bus.illegal);
    end
    tick();
    tests++;
    if ({bus.id_valid, bus.id_reg_write} !== 2'b00) begin
      fails++; $display("FAIL addi_reg: got v=%b rw=%b expected 0/0", bus.id_valid, bus.id_reg_write);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_jump_beq();
    test_illegal();
    test_stall_flush();
    test_back_to_back();
    test_reset_mid();
    test_ext_ops();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
